// File: rtl/ladybird_uart_pkg.sv
// Shared types and helpers for the ladybird UART transmit path.
package ladybird_uart_pkg;

  // Widest divisor the frame shadow can hold; DIV_WIDTH must not exceed it.
  localparam int DIV_MAX_W = 32;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef struct packed {
    logic [DIV_MAX_W-1:0] div;
    logic [1:0]           bits;
    parity_e              parity;
    logic                 stop2;
  } frame_cfg_t;

  // Parity code 3 is an alias for "no parity".
  function automatic parity_e decode_parity(input logic [1:0] code);
    case (code)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  // Keeps only the data bits that go on the wire for a given width code.
  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    case (bits)
      2'd0:    return 8'h1F;
      2'd1:    return 8'h3F;
      2'd2:    return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Index of the last data bit (N-1) for a given width code.
  function automatic logic [2:0] last_bit_index(input logic [1:0] bits);
    return {1'b0, bits} + 3'd4;
  endfunction

endpackage

// File: rtl/ladybird_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head entry is always presented on rdata.
module ladybird_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra wrap bit separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; emptiness comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ladybird_uart_tx_fifo.sv
// UART transmitter with a queued byte input and a per-frame latched format.
module ladybird_uart_tx_fifo
  import ladybird_uart_pkg::*;
#(
  parameter int                   DEPTH       = 16,
  parameter int                   DIV_WIDTH   = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'h28B0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [7:0]               data,
  output logic                     ready,
  input  logic [DIV_WIDTH-1:0]     cfg_div,
  input  logic [1:0]               cfg_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_stop2,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  tx_state_e            state, state_n;
  frame_cfg_t           shadow, shadow_n;
  logic [DIV_MAX_W-1:0] cnt, cnt_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic [7:0]           shift, shift_n;
  logic                 par_bit, par_bit_n;
  logic                 stop_idx, stop_idx_n;
  logic                 tx_q, tx_n;
  logic                 start_frame;
  logic                 pop;

  logic [7:0]           fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;

  logic [DIV_MAX_W-1:0] new_div;
  logic [DIV_MAX_W-1:0] new_m1;
  logic [DIV_MAX_W-1:0] cur_m1;
  logic [7:0]           new_data;
  parity_e              new_par;

  assign ready = !fifo_full;

  ladybird_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid && ready),
    .wdata (data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // A divisor of 0 behaves like 1, so the reload value saturates at 0.
  assign new_div  = DIV_MAX_W'(cfg_div);
  assign new_m1   = (new_div == '0) ? '0 : new_div - DIV_MAX_W'(1);
  assign cur_m1   = (shadow.div == '0) ? '0 : shadow.div - DIV_MAX_W'(1);
  assign new_data = fifo_rdata & data_mask(cfg_bits);
  assign new_par  = decode_parity(cfg_parity);

  // Next-state logic: walks start/data/parity/stop and chains frames without a gap.
  always_comb begin
    state_n     = state;
    shadow_n    = shadow;
    cnt_n       = cnt;
    bit_idx_n   = bit_idx;
    shift_n     = shift;
    par_bit_n   = par_bit;
    stop_idx_n  = stop_idx;
    tx_n        = tx_q;
    start_frame = 1'b0;
    pop         = 1'b0;

    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (cnt == '0) begin
          state_n   = DATA;
          cnt_n     = cur_m1;
          bit_idx_n = 3'd0;
          tx_n      = shift[0];
        end else begin
          cnt_n = cnt - DIV_MAX_W'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = cur_m1;
          if (bit_idx == last_bit_index(shadow.bits)) begin
            if (shadow.parity != PAR_NONE) begin
              state_n = PARITY;
              tx_n    = par_bit;
            end else begin
              state_n    = STOP;
              stop_idx_n = 1'b0;
              tx_n       = 1'b1;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = shift >> 1;
            tx_n      = shift[1];
          end
        end else begin
          cnt_n = cnt - DIV_MAX_W'(1);
        end
      end
      PARITY: begin
        if (cnt == '0) begin
          state_n    = STOP;
          cnt_n      = cur_m1;
          stop_idx_n = 1'b0;
          tx_n       = 1'b1;
        end else begin
          cnt_n = cnt - DIV_MAX_W'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (shadow.stop2 && !stop_idx) begin
            stop_idx_n = 1'b1;
            cnt_n      = cur_m1;
          end else if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt - DIV_MAX_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    if (start_frame) begin
      pop       = 1'b1;
      state_n   = START;
      tx_n      = 1'b0;
      cnt_n     = new_m1;
      shift_n   = new_data;
      par_bit_n = (^new_data) ^ (new_par == PAR_ODD);
      shadow_n  = '{div: new_div, bits: cfg_bits, parity: new_par, stop2: cfg_stop2};
    end
  end

  // State register; reset parks the line high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shadow   <= '{div: DIV_MAX_W'(DEFAULT_DIV), bits: 2'd3, parity: PAR_NONE, stop2: 1'b0};
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'd0;
      par_bit  <= 1'b0;
      stop_idx <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      par_bit  <= par_bit_n;
      stop_idx <= stop_idx_n;
      tx_q     <= tx_n;
    end
  end

  assign tx   = tx_q;
  assign busy = (state != IDLE) || (level != '0);

endmodule

// File: tb/tb_ladybird_uart_tx_fifo.sv
// Self-checking bench: fixed frame vectors, hand corner cases and a random run
// compared against a waveform-level reference model.
module tb_ladybird_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [7:0]    data;
  logic          ready;
  logic [15:0]   cfg_div;
  logic [1:0]    cfg_bits;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2;
  logic          tx;
  logic          busy;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  ladybird_uart_tx_fifo #(
    .DEPTH       (DEPTH),
    .DIV_WIDTH   (16),
    .DEFAULT_DIV (16'h28B0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .data       (data),
    .ready      (ready),
    .cfg_div    (cfg_div),
    .cfg_bits   (cfg_bits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx         (tx),
    .busy       (busy),
    .level      (level)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: queued bytes plus the exact per-cycle line waveform still to be sent
  logic [7:0] model_q[$];
  logic       wave[$];
  bit         m_pop;
  bit         m_push;

  task automatic add_frame(input logic [7:0] d, input int div, input int bits,
                           input int par, input bit stop2);
    int dd;
    int n;
    int ones;
    logic pbit;
    dd   = (div == 0) ? 1 : div;
    n    = bits + 5;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    for (int c = 0; c < dd; c++) wave.push_back(1'b0);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < dd; c++) wave.push_back(d[i]);
    if (par == 1 || par == 2) begin
      pbit = (ones % 2 == 1);
      if (par == 2) pbit = !pbit;
      for (int c = 0; c < dd; c++) wave.push_back(pbit);
    end
    for (int s = 0; s < (stop2 ? 2 : 1); s++)
      for (int c = 0; c < dd; c++) wave.push_back(1'b1);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      wave.delete();
    end else begin
      m_pop  = (wave.size() <= 1) && (model_q.size() > 0);
      m_push = valid && (model_q.size() < DEPTH);
      if (wave.size() > 0) void'(wave.pop_front());
      if (m_pop) add_frame(model_q.pop_front(), int'(cfg_div), int'(cfg_bits),
                           int'(cfg_parity), cfg_stop2);
      if (m_push) model_q.push_back(data);
    end
  end

  // Every cycle out of reset, compare all outputs against the model
  always @(negedge clk) begin
    if (!rst) begin
      check_output("model_tx",    64'(tx),    64'((wave.size() > 0) ? wave[0] : 1'b1));
      check_output("model_level", 64'(level), 64'(model_q.size()));
      check_output("model_ready", 64'(ready), 64'(model_q.size() < DEPTH));
      check_output("model_busy",  64'(busy),  64'((wave.size() > 0) || (model_q.size() > 0)));
    end
  end

  // Frame vectors: line is written in time order, leftmost bit first
  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic [1:0]  bits;
    logic [1:0]  parity;
    logic        stop2;
    int          nbits;
    logic [11:0] line;
  } vec_t;

  vec_t vecs[8];

  // Offers a byte at a negedge and returns at the negedge after it is accepted; valid stays high
  task automatic push_byte(input logic [7:0] d);
    int waited;
    waited = 0;
    valid  = 1'b1;
    data   = d;
    while (!ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      check_output("push_timeout", 64'(ready), 64'd1);
      valid = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string name);
    logic [63:0] act;
    logic [63:0] exp;
    int d;
    int total;
    act        = '0;
    exp        = '0;
    cfg_div    = v.div;
    cfg_bits   = v.bits;
    cfg_parity = v.parity;
    cfg_stop2  = v.stop2;
    push_byte(v.data);
    valid = 1'b0;
    check_output({name, "_pre_start"}, 64'({tx, level}), 64'({1'b1, LW'(1)}));
    d     = (v.div == 16'd0) ? 1 : int'(v.div);
    total = v.nbits * d;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      act[k] = tx;
      exp[k] = v.line[v.nbits - 1 - k / d];
    end
    check_output({name, "_line"}, act, exp);
    @(negedge clk);
    check_output({name, "_busy_drop"}, 64'({busy, tx}), 64'(2'b01));
  endtask

  // Hard stop if anything hangs
  initial begin
    #5ms;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int c0;

    vecs[0] = '{8'hA5, 16'd4, 2'd3, 2'd0, 1'b0, 10, 12'b0101001011};
    vecs[1] = '{8'h41, 16'd3, 2'd2, 2'd1, 1'b1, 11, 12'b01000001011};
    vecs[2] = '{8'h43, 16'd3, 2'd2, 2'd2, 1'b1, 11, 12'b01100001011};
    vecs[3] = '{8'h00, 16'd0, 2'd3, 2'd0, 1'b0, 10, 12'b0000000001};
    vecs[4] = '{8'h00, 16'd1, 2'd3, 2'd0, 1'b0, 10, 12'b0000000001};
    vecs[5] = '{8'hFF, 16'd2, 2'd0, 2'd3, 1'b0, 7,  12'b0111111};
    vecs[6] = '{8'h00, 16'd2, 2'd3, 2'd2, 1'b0, 11, 12'b00000000011};
    vecs[7] = '{8'h5A, 16'd4, 2'd3, 2'd0, 1'b0, 10, 12'b0010110101};

    rst        = 1'b1;
    valid      = 1'b0;
    data       = 8'h00;
    cfg_div    = 16'd4;
    cfg_bits   = 2'd3;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b0;

    repeat (2) @(negedge clk);
    check_output("reset_tx",    64'(tx),    64'd1);
    check_output("reset_ready", 64'(ready), 64'd1);
    check_output("reset_busy",  64'(busy),  64'd0);
    check_output("reset_level", 64'(level), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);

    $display("[TB] frame vectors");
    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    $display("[TB] config change mid-frame");
    cfg_div    = 16'd2;
    cfg_bits   = 2'd3;
    cfg_parity = 2'd0;
    cfg_stop2  = 1'b0;
    push_byte(8'hFF);
    push_byte(8'hFF);
    valid    = 1'b0;
    cfg_bits = 2'd0;
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("midcfg_busy_len", 64'(n), 64'(10 * 2 + 7 * 2));
    cfg_bits = 2'd3;

    $display("[TB] back-to-back burst");
    push_byte(8'h10);
    c0 = cyc;
    push_byte(8'h11);
    push_byte(8'h12);
    push_byte(8'h13);
    push_byte(8'h14);
    check_output("burst_full_ready", 64'(ready), 64'd0);
    check_output("burst_full_level", 64'(level), 64'(DEPTH));
    push_byte(8'h15);
    valid = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_output("burst_len", 64'(cyc - c0), 64'(1 + 6 * 20));

    $display("[TB] reset during data bit 3");
    cfg_div = 16'd4;
    push_byte(8'h00);
    push_byte(8'h00);
    valid = 1'b0;
    repeat (17) @(negedge clk);
    check_output("pre_reset_tx",    64'(tx),    64'd0);
    check_output("pre_reset_level", 64'(level), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_output("async_reset_tx",    64'(tx),    64'd1);
    check_output("async_reset_level", 64'(level), 64'd0);
    check_output("async_reset_ready", 64'(ready), 64'd1);
    check_output("async_reset_busy",  64'(busy),  64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    apply_stimulus(vecs[7], "post_reset");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2500; i++) begin
      valid = ($urandom_range(0, 2) != 0);
      data  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        cfg_div    = 16'($urandom_range(0, 3));
        cfg_bits   = 2'($urandom_range(0, 3));
        cfg_parity = 2'($urandom_range(0, 3));
        cfg_stop2  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    valid = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("random_drain_busy", 64'(busy), 64'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
